// File: rtl/sig_add_stage.sv
// sig_add_stage: significand add/subtract stage of the FP adder.
// This stage sits directly after alignment. It computes |fa2 +/- fb3| and
// passes the result sign, the carry-extended magnitude and a zero flag on to
// normalize/round. It is a two-stage valid/ready pipeline (S1: add/sub,
// S2: abs/sign/zero). Under output back-pressure it stalls without losing beats.
//
// Optional build macro: SIG_ADD_SKID_EN
//   When defined, a 1-entry skid buffer sits in front of S1, so in_ready
//   comes straight from a flop.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   es                  result exponent (larger of ea/eb)
//   fa2                 larger-exponent significand, FW bits incl. hidden bit
//   fb3                 aligned smaller significand {shifted, sticky}, FW+3 bits
//   sa2, sb2            operand signs
//   sx                  effective subtract
//   out_valid/out_ready downstream handshake
//   es_o                exponent, passed through unchanged
//   fs                  magnitude; bit FW+3 = carry, binary point after bit FW+2
//   ss                  result sign
//   zero                fs == 0
module sig_add_stage #(
  parameter int EW = 11,
  parameter int FW = 53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] es,
  input  logic [FW-1:0] fa2,
  input  logic [FW+2:0] fb3,
  input  logic          sa2,
  input  logic          sb2,
  input  logic          sx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] es_o,
  output logic [FW+3:0] fs,
  output logic          ss,
  output logic          zero
);

  typedef struct packed {
    logic [EW-1:0] es;
    logic [FW-1:0] fa2;
    logic [FW+2:0] fb3;
    logic          sa2;
    logic          sb2;
    logic          sx;
  } req_t;

  req_t          in_req, s1_src;
  logic          src_vld;
  logic [2:1]    vld_pipe;
  logic          s1_adv, s2_adv;

  // S1 state
  logic [EW-1:0] s1_es;
  logic          s1_sa2, s1_sb2, s1_sx;
  logic [FW+4:0] s1_raw;

  assign in_req = {es, fa2, fb3, sa2, sb2, sx};

  // A stage advances when it is empty or its downstream consumer takes data.
  assign s2_adv = !vld_pipe[2] | out_ready;
  assign s1_adv = !vld_pipe[1] | s2_adv;

`ifdef SIG_ADD_SKID_EN
  req_t skid_q;
  logic skid_vld;

  // A parked beat always goes into S1 ahead of new input, so order is kept.
  // While the skid is full, in_ready is low and the input is not looked at.
  assign in_ready = !skid_vld;
  assign src_vld  = skid_vld | in_valid;
  assign s1_src   = skid_vld ? skid_q : in_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (skid_vld) begin
      if (s1_adv) skid_vld <= 1'b0;
    end else if (in_valid && !s1_adv) begin
      skid_vld <= 1'b1;
      skid_q   <= in_req;
    end
  end
`else
  assign in_ready = s1_adv;
  assign src_vld  = in_valid;
  assign s1_src   = in_req;
`endif

  // S1 datapath. One extra MSB is used so that a negative difference shows
  // up as raw[FW+4]. The sticky bit (fb3[0]) is the LSB of B.
  logic [FW+4:0] a_ext, b_ext, raw_d;
  assign a_ext = {2'b00, s1_src.fa2, 3'b000};
  assign b_ext = {2'b00, s1_src.fb3};
  assign raw_d = s1_src.sx ? (a_ext - b_ext) : (a_ext + b_ext);

  // S2 datapath: absolute value, sign, zero. A carry in fs[FW+3] is passed
  // through untouched; normalize deals with it.
  logic          neg;
  logic [FW+3:0] fs_d;
  logic          zero_d, ss_d;
  assign neg    = s1_sx & s1_raw[FW+4];
  assign fs_d   = neg ? (~s1_raw[FW+3:0] + 1'b1) : s1_raw[FW+3:0];
  assign zero_d = (fs_d == '0);
  // Exact cancellation gives +0 (round-to-nearest-even).
  assign ss_d   = (s1_sx && zero_d) ? 1'b0 : (s1_sa2 ^ neg);

  // sb2 is registered together with the other signs. The result does not need
  // it because sx already carries sa2^sb2.
  logic unused_sb2;
  assign unused_sb2 = s1_sb2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_es    <= '0;
      s1_sa2   <= 1'b0;
      s1_sb2   <= 1'b0;
      s1_sx    <= 1'b0;
      s1_raw   <= '0;
      es_o     <= '0;
      fs       <= '0;
      ss       <= 1'b0;
      zero     <= 1'b1;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          es_o <= s1_es;
          fs   <= fs_d;
          ss   <= ss_d;
          zero <= zero_d;
        end
      end
      if (s1_adv) begin
        vld_pipe[1] <= src_vld;
        if (src_vld) begin
          s1_es  <= s1_src.es;
          s1_sa2 <= s1_src.sa2;
          s1_sb2 <= s1_src.sb2;
          s1_sx  <= s1_src.sx;
          s1_raw <= raw_d;
        end
      end
    end
  end

  assign out_valid = vld_pipe[2];

endmodule
